// File: rtl/sub_4_serial.sv
// Bit-serial subtractor: {bout,out} = in_0 - in_1 - bin, one bit per cycle, LSB first.
// Optional build macro SUB_4_SERIAL_SAT_EN clamps a borrowing result to zero.
module sub_4_serial #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_0,
   input  logic [WIDTH-1:0] in_1,
   input  logic             bin,
   input  logic             start,
   output logic [WIDTH-1:0] out,
   output logic             bout,
   output logic             busy,
   output logic             done
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             br_q, br_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             bout_q, bout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             diff_bit;
   logic             br_next;

   // One full-subtractor slice operating on the current LSBs of the operand shifters.
   assign diff_bit = a_q[0] ^ b_q[0] ^ br_q;
   assign br_next  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

   // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      br_d    = br_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      bout_d  = bout_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = in_0;
               b_d     = in_1;
               br_d    = bin;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            res_d = {diff_bit, res_q[WIDTH-1:1]};
            br_d  = br_next;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_BIT) begin
               busy_d  = 1'b0;
               state_d = DONE;
            end
         end
         DONE: begin
`ifdef SUB_4_SERIAL_SAT_EN
            out_d  = br_q ? '0 : res_q;
`else
            out_d  = res_q;
`endif
            bout_d = br_q;
            done_d = 1'b1;
            // Results are published and new operands latched on the same edge.
            if (start) begin
               a_d     = in_0;
               b_d     = in_1;
               br_d    = bin;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; reset is synchronous here.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         br_q    <= 1'b0;
         cnt_q   <= '0;
         out_q   <= '0;
         bout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         br_q    <= br_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         bout_q  <= bout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign out  = out_q;
   assign bout = bout_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_sub_4_serial.sv
// Directed bench for sub_4_serial (WIDTH=4); expected values are hand-computed constants.
module tb_sub_4_serial;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] in_0;
   logic [3:0] in_1;
   logic       bin;
   logic       start;
   logic [3:0] out;
   logic       bout;
   logic       busy;
   logic       done;

   int n_checks = 0;
   int n_fail   = 0;

   logic [3:0] hold_out = 4'd0;
   logic       hold_bout = 1'b0;

`ifdef SUB_4_SERIAL_SAT_EN
   localparam logic [3:0] NEG_3_9 = 4'd0;
   localparam logic [3:0] NEG_0_1 = 4'd0;
   localparam logic [3:0] NEG_1_2 = 4'd0;
`else
   localparam logic [3:0] NEG_3_9 = 4'd10;
   localparam logic [3:0] NEG_0_1 = 4'd15;
   localparam logic [3:0] NEG_1_2 = 4'd15;
`endif

   sub_4_serial #(.WIDTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .in_0  (in_0),
      .in_1  (in_1),
      .bin   (bin),
      .start (start),
      .out   (out),
      .bout  (bout),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   // Start at a negedge; acceptance edge is T, cyc k is the negedge after edge T+k.
   task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic bi,
                        input logic [3:0] eo, input logic eb, input string name);
      in_0 = a; in_1 = b; bin = bi; start = 1'b1;
      @(negedge clk);
      start = 1'b0; in_0 = ~a; in_1 = ~b; bin = ~bi;
      for (int cyc = 0; cyc < 8; cyc++) begin
         if (cyc > 0) @(negedge clk);
         n_checks++;
         if (busy !== (cyc < 4)) begin
            n_fail++;
            $display("FAIL %s busy cyc%0d: got %b want %b", name, cyc, busy, (cyc < 4));
         end
         n_checks++;
         if (done !== (cyc == 5)) begin
            n_fail++;
            $display("FAIL %s done cyc%0d: got %b want %b", name, cyc, done, (cyc == 5));
         end
         if (cyc < 5) begin
            n_checks++;
            if (out !== hold_out || bout !== hold_bout) begin
               n_fail++;
               $display("FAIL %s hold cyc%0d: got %0d/%b want %0d/%b", name, cyc, out, bout, hold_out, hold_bout);
            end
         end
         if (cyc == 5) begin
            n_checks++;
            if (out !== eo || bout !== eb) begin
               n_fail++;
               $display("FAIL %s result: got %0d/%b want %0d/%b", name, out, bout, eo, eb);
            end
         end
      end
      hold_out = eo; hold_bout = eb;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b1; in_0 = 4'd9; in_1 = 4'd3; bin = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (out !== 4'd0 || bout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset state: got out=%0d bout=%b busy=%b done=%b want 0/0/0/0", out, bout, busy, done);
      end
      // First edge with rst_n=1 must accept the start.
      rst_n = 1'b1;
      do_op(4'd9, 4'd3, 1'b0, 4'd6, 1'b0, "first_start_9m3");
   endtask

   task automatic test_subtract;
      do_op(4'd3,  4'd9,  1'b0, NEG_3_9, 1'b1, "neg_3m9");
      do_op(4'd0,  4'd0,  1'b1, NEG_0_1, 1'b1, "bin_only");
      do_op(4'd15, 4'd15, 1'b0, 4'd0,    1'b0, "15m15");
      do_op(4'd10, 4'd4,  1'b1, 4'd5,    1'b0, "10m4m1");
   endtask

   task automatic test_start_busy;
      in_0 = 4'd5; in_1 = 4'd2; bin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 0; cyc < 16; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (cyc == 1) begin
            in_0 = 4'd12; in_1 = 4'd1; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         n_checks++;
         if (done !== (cyc == 5)) begin
            n_fail++;
            $display("FAIL start_busy done cyc%0d: got %b want %b", cyc, done, (cyc == 5));
         end
         if (cyc == 5) begin
            n_checks++;
            if (out !== 4'd3 || bout !== 1'b0) begin
               n_fail++;
               $display("FAIL start_busy result: got %0d/%b want 3/0", out, bout);
            end
         end
      end
      hold_out = 4'd3; hold_bout = 1'b0;
   endtask

   task automatic test_back_to_back;
      in_0 = 4'd7; in_1 = 4'd7; bin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 1; cyc <= 4; cyc++) @(negedge clk);
      // Cycle in DONE state: hold start with the next operands.
      in_0 = 4'd1; in_1 = 4'd2; bin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (done !== 1'b1 || out !== 4'd0 || bout !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b first: got done=%b out=%0d bout=%b busy=%b want 1/0/0/1", done, out, bout, busy);
      end
      for (int cyc = 6; cyc <= 12; cyc++) begin
         @(negedge clk);
         n_checks++;
         if (done !== (cyc == 10)) begin
            n_fail++;
            $display("FAIL b2b done cyc%0d: got %b want %b", cyc, done, (cyc == 10));
         end
         if (cyc == 10) begin
            n_checks++;
            if (out !== NEG_1_2 || bout !== 1'b1) begin
               n_fail++;
               $display("FAIL b2b second: got %0d/%b want %0d/1", out, bout, NEG_1_2);
            end
         end
      end
      hold_out = NEG_1_2; hold_bout = 1'b1;
   endtask

   task automatic test_reset_mid;
      in_0 = 4'd9; in_1 = 4'd3; bin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (out !== 4'd0 || bout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid state: got out=%0d bout=%b busy=%b done=%b want 0/0/0/0", out, bout, busy, done);
      end
      rst_n = 1'b1;
      for (int cyc = 0; cyc < 10; cyc++) begin
         @(negedge clk);
         n_checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid quiet cyc%0d: got done=%b busy=%b want 0/0", cyc, done, busy);
         end
      end
      hold_out = 4'd0; hold_bout = 1'b0;
      do_op(4'd8, 4'd1, 1'b0, 4'd7, 1'b0, "after_reset_8m1");
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; in_0 = '0; in_1 = '0; bin = 1'b0;
      @(negedge clk);
      test_reset;
      test_subtract;
      test_start_busy;
      test_back_to_back;
      test_reset_mid;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
